// File: rtl/hssi_tc_mailbox_pkg.sv
// rtl/hssi_tc_mailbox_pkg.sv - shared mailbox offsets, command codes, CMD layout and FSM states
package hssi_tc_mailbox_pkg;

  localparam logic [3:0] OFF_CMD     = 4'h0;
  localparam logic [3:0] OFF_ADDRESS = 4'h4;
  localparam logic [3:0] OFF_RDDATA  = 4'h8;
  localparam logic [3:0] OFF_WRDATA  = 4'hC;

  localparam logic [1:0] CMD_NOOP = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  channel;
    logic [1:0]  rsvd_lo;
    logic        illegal_err;
    logic        timeout_err;
    logic        busy;
    logic        ack;
    logic [1:0]  cmd;
  } cmd_reg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/hssi_mb_timeout.sv
// rtl/hssi_mb_timeout.sv - saturating access timeout counter
module hssi_mb_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LAST so a late transition into WAIT_RD still sees the expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/hssi_tc_mailbox.sv
// rtl/hssi_tc_mailbox.sv - CSR mailbox issuing indirect accesses to per-channel traffic controllers
module hssi_tc_mailbox
  import hssi_tc_mailbox_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TC_ADDR_W   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csr_wr,
  input  logic                    csr_rd,
  input  logic [3:0]              csr_addr,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  output logic                    csr_rvalid,
  output logic [NUM_CH-1:0]       tc_read,
  output logic [NUM_CH-1:0]       tc_write,
  output logic [TC_ADDR_W-1:0]    tc_addr,
  output logic [31:0]             tc_wdata,
  input  logic [NUM_CH-1:0]       tc_waitrequest,
  input  logic [NUM_CH*32-1:0]    tc_rdata,
  input  logic [NUM_CH-1:0]       tc_rdvalid
);

  state_t      state;
  cmd_reg_t    cmd_r;
  logic [31:0] address_r, rddata_r, wrdata_r;

  logic [NUM_CH-1:0] ch_sel;
  logic              req_taken, rd_hit, expire, active;
  logic [31:0]       rd_slice;
  logic [1:0]        wcmd;
  logic [3:0]        wch;
  logic              cmd_wr, illegal, start;

  assign ch_sel    = NUM_CH'(1) << cmd_r.channel;
  assign req_taken = ~|(tc_waitrequest & ch_sel);
  assign rd_hit    = |(tc_rdvalid & ch_sel);
  assign rd_slice  = 32'(tc_rdata >> {cmd_r.channel, 5'd0});

  assign wcmd    = csr_wdata[1:0];
  assign wch     = csr_wdata[11:8];
  assign cmd_wr  = csr_wr && (csr_addr == OFF_CMD) && !cmd_r.busy;
  assign illegal = (wcmd == CMD_RSVD) || (32'(wch) >= NUM_CH);
  assign start   = cmd_wr && !illegal && (wcmd != CMD_NOOP);
  assign active  = (state == ST_ISSUE) || (state == ST_WAIT_RD);

  // Requests decode straight from state so an async reset drops them immediately
  assign tc_read  = (state == ST_ISSUE && cmd_r.cmd == CMD_RD) ? ch_sel : '0;
  assign tc_write = (state == ST_ISSUE && cmd_r.cmd == CMD_WR) ? ch_sel : '0;
  assign tc_addr  = address_r[TC_ADDR_W-1:0];
  assign tc_wdata = wrdata_r;

  hssi_mb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (active),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_r      <= '0;
      address_r  <= '0;
      rddata_r   <= '0;
      wrdata_r   <= '0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_rd;
      if (csr_rd) begin
        case (csr_addr)
          OFF_CMD:     csr_rdata <= cmd_r;
          OFF_ADDRESS: csr_rdata <= address_r;
          OFF_RDDATA:  csr_rdata <= rddata_r;
          OFF_WRDATA:  csr_rdata <= wrdata_r;
          default:     csr_rdata <= '0;
        endcase
      end

      if (csr_wr && !cmd_r.busy) begin
        if (csr_addr == OFF_ADDRESS) address_r <= csr_wdata;
        if (csr_addr == OFF_WRDATA)  wrdata_r  <= csr_wdata;
      end

      if (cmd_wr) begin
        cmd_r.cmd         <= wcmd;
        cmd_r.channel     <= wch;
        cmd_r.timeout_err <= 1'b0;
        cmd_r.illegal_err <= illegal;
        cmd_r.ack         <= !start;
        cmd_r.busy        <= start;
      end

      case (state)
        ST_IDLE: if (start) state <= ST_ISSUE;
        ST_ISSUE: begin
          if (req_taken) begin
            state <= (cmd_r.cmd == CMD_RD) ? ST_WAIT_RD : ST_DONE;
          end else if (expire) begin
            cmd_r.timeout_err <= 1'b1;
            if (cmd_r.cmd == CMD_RD) rddata_r <= 32'hFFFF_FFFF;
            state <= ST_DONE;
          end
        end
        ST_WAIT_RD: begin
          // Data arriving on the expiry cycle takes priority over the timeout
          if (rd_hit) begin
            rddata_r <= rd_slice;
            state    <= ST_DONE;
          end else if (expire) begin
            cmd_r.timeout_err <= 1'b1;
            rddata_r          <= 32'hFFFF_FFFF;
            state             <= ST_DONE;
          end
        end
        ST_DONE: begin
          cmd_r.busy <= 1'b0;
          cmd_r.ack  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hssi_tc_mailbox.sv
// tb/tb_hssi_tc_mailbox.sv - directed self-checking bench for hssi_tc_mailbox
module tb_hssi_tc_mailbox;

  localparam int NUM_CH    = 4;
  localparam int TC_ADDR_W = 16;
  localparam int TO        = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  csr_wr = 1'b0, csr_rd = 1'b0;
  logic [3:0]            csr_addr = '0;
  logic [31:0]           csr_wdata = '0;
  logic [31:0]           csr_rdata;
  logic                  csr_rvalid;
  logic [NUM_CH-1:0]     tc_read, tc_write;
  logic [TC_ADDR_W-1:0]  tc_addr;
  logic [31:0]           tc_wdata;
  logic [NUM_CH-1:0]     tc_waitrequest = '0;
  logic [NUM_CH*32-1:0]  tc_rdata = '0;
  logic [NUM_CH-1:0]     tc_rdvalid = '0;

  int n_checks = 0, n_fail = 0;
  int wr_pulses = 0, rd_pulses = 0, onehot_err = 0;
  logic [3:0]  last_wr = '0, last_rd = '0;
  logic [15:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] rv;

  hssi_tc_mailbox #(.NUM_CH(NUM_CH), .TC_ADDR_W(TC_ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .tc_read(tc_read), .tc_write(tc_write), .tc_addr(tc_addr), .tc_wdata(tc_wdata),
    .tc_waitrequest(tc_waitrequest), .tc_rdata(tc_rdata), .tc_rdvalid(tc_rdvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tc_write != 0) begin
      wr_pulses++; last_wr = tc_write; last_addr = tc_addr; last_wdata = tc_wdata;
    end
    if (tc_read != 0) begin
      rd_pulses++; last_rd = tc_read; last_addr = tc_addr;
    end
    if ($countones({tc_read, tc_write}) > 1) onehot_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    csr_rd = 1'b1; csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    chk("rvalid", 32'(csr_rvalid), 32'd1);
    d = csr_rdata;
  endtask

  task automatic clr_mon();
    wr_pulses = 0; rd_pulses = 0; last_wr = '0; last_rd = '0;
  endtask

  initial begin
    #1;
    chk("rst_tc_read", 32'(tc_read), 32'd0);
    chk("rst_tc_write", 32'(tc_write), 32'd0);
    chk("rst_tc_addr", 32'(tc_addr), 32'd0);
    chk("rst_rvalid", 32'(csr_rvalid), 32'd0);
    chk("rst_rdata", csr_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    csr_read(4'h0, rv); chk("rst_cmd", rv, 32'h0);
    csr_read(4'h8, rv); chk("rst_rddata", rv, 32'h0);

    // write to channel 2
    clr_mon();
    csr_write(4'h4, 32'h200);
    csr_write(4'hC, 32'h1);
    csr_write(4'h0, 32'h202);
    repeat (3) @(negedge clk);
    chk("wr_pulses", 32'(wr_pulses), 32'd1);
    chk("wr_vec", 32'(last_wr), 32'h4);
    chk("wr_addr", 32'(last_addr), 32'h200);
    chk("wr_wdata", last_wdata, 32'h1);
    csr_read(4'h0, rv); chk("wr_cmd", rv, 32'h206);
    csr_read(4'h4, rv); chk("wr_address_rb", rv, 32'h200);

    // stray rdvalid while idle must not touch RDDATA
    tc_rdvalid = 4'b1000; tc_rdata[96 +: 32] = 32'h1111_1111;
    @(negedge clk);
    tc_rdvalid = '0;
    csr_read(4'h8, rv); chk("idle_rdvalid_ignored", rv, 32'h0);

    // read from channel 3
    clr_mon();
    csr_write(4'h4, 32'h101);
    csr_write(4'h0, 32'h301);
    csr_read(4'h0, rv); chk("rd_busy", rv, 32'h309);
    repeat (3) @(negedge clk);
    tc_rdvalid = 4'b0010; tc_rdata[32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    tc_rdvalid = 4'b1000; tc_rdata[96 +: 32] = 32'hA5A5_0007;
    @(negedge clk);
    tc_rdvalid = '0;
    csr_read(4'h8, rv); chk("rd_data", rv, 32'hA5A5_0007);
    csr_read(4'h0, rv); chk("rd_cmd", rv, 32'h305);
    chk("rd_pulses", 32'(rd_pulses), 32'd1);
    chk("rd_vec", 32'(last_rd), 32'h8);
    chk("rd_addr", 32'(last_addr), 32'h101);

    // writes while busy are dropped
    clr_mon();
    csr_write(4'h0, 32'h101);
    repeat (2) @(negedge clk);
    csr_write(4'h0, 32'h202);
    csr_write(4'h4, 32'h555);
    csr_write(4'hC, 32'h99);
    tc_rdvalid = 4'b0010; tc_rdata[32 +: 32] = 32'h1234_5678;
    @(negedge clk);
    tc_rdvalid = '0;
    repeat (2) @(negedge clk);
    csr_read(4'h8, rv); chk("busy_rddata", rv, 32'h1234_5678);
    csr_read(4'h0, rv); chk("busy_cmd", rv, 32'h105);
    csr_read(4'h4, rv); chk("busy_address", rv, 32'h101);
    csr_read(4'hC, rv); chk("busy_wrdata", rv, 32'h1);
    chk("busy_no_write", 32'(wr_pulses), 32'd0);
    chk("busy_rd_vec", 32'(last_rd), 32'h2);

    // timeout on channel 0, cycle-exact status progression
    csr_write(4'h0, 32'h001);
    repeat (TO - 1) @(negedge clk);
    csr_read(4'h0, rv); chk("to_still_busy", rv, 32'h009);
    csr_read(4'h0, rv); chk("to_done_state", rv, 32'h019);
    csr_read(4'h0, rv); chk("to_ack", rv, 32'h015);
    csr_read(4'h8, rv); chk("to_rddata", rv, 32'hFFFF_FFFF);

    // rdvalid on the expiry cycle wins over the timeout
    csr_write(4'h0, 32'h001);
    repeat (TO - 1) @(negedge clk);
    tc_rdvalid = 4'b0001; tc_rdata[0 +: 32] = 32'h0BAD_F00D;
    @(negedge clk);
    tc_rdvalid = '0;
    repeat (2) @(negedge clk);
    csr_read(4'h8, rv); chk("race_rddata", rv, 32'h0BAD_F00D);
    csr_read(4'h0, rv); chk("race_cmd", rv, 32'h005);

    // illegal commands and NOOP
    clr_mon();
    csr_write(4'h0, 32'h403);
    repeat (2) @(negedge clk);
    csr_read(4'h0, rv); chk("ill_cmd3_ch4", rv, 32'h427);
    csr_write(4'h0, 32'h501);
    repeat (2) @(negedge clk);
    csr_read(4'h0, rv); chk("ill_ch5", rv, 32'h525);
    csr_write(4'h0, 32'h100);
    @(negedge clk);
    csr_read(4'h0, rv); chk("noop_cmd", rv, 32'h104);
    chk("ill_no_pulse", 32'(wr_pulses + rd_pulses), 32'd0);

    // reset during a stalled ISSUE
    tc_waitrequest = 4'hF;
    csr_write(4'h4, 32'h3C);
    csr_write(4'hC, 32'h7);
    csr_write(4'h0, 32'h202);
    repeat (2) @(negedge clk);
    chk("pre_rst_write", 32'(tc_write), 32'h4);
    chk("pre_rst_addr", 32'(tc_addr), 32'h3C);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_write", 32'(tc_write), 32'd0);
    chk("mid_rst_addr", 32'(tc_addr), 32'd0);
    chk("mid_rst_wdata", tc_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tc_waitrequest = '0;
    clr_mon();
    repeat (4) @(negedge clk);
    chk("post_rst_no_write", 32'(wr_pulses), 32'd0);
    csr_read(4'h0, rv); chk("post_rst_cmd", rv, 32'h0);

    // read and write of the same register in one cycle returns the old value
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 4'h4; csr_wdata = 32'h77;
    @(negedge clk);
    csr_wr = 1'b0; csr_rd = 1'b0;
    chk("rdwr_old_value", csr_rdata, 32'h0);
    csr_read(4'h4, rv); chk("rdwr_new_value", rv, 32'h77);

    chk("onehot", 32'(onehot_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
